// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // One extra bit so the counter can represent WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_sub_fs_v1.sv
// Combinational full subtractor cell: diff = a - b - borrow_in, one bit.
module fs_v1 (
    output logic diff,
    output logic borrow_out,
    input  logic a,
    input  logic b,
    input  logic borrow_in
);

    assign diff       = a ^ b ^ borrow_in;
    assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial N-bit subtractor: diff = a - b - b_in, LSB first through a single
// full-subtractor cell, with start/busy/done handshake and borrow/overflow flags.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_r;
    state_t           next_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_r;
    logic [CW-1:0]    cnt_r;
    logic             br_r;
    logic             d_s;
    logic             bo_s;
    logic             last_s;
    logic             br_msb_s;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_r;
    logic             overflow_r;
    logic             busy_r;
    logic             done_r;

    fs_v1 u_fs (
        .diff      (d_s),
        .borrow_out(bo_s),
        .a         (a_sh_r[0]),
        .b         (b_sh_r[0]),
        .borrow_in (br_r)
    );

    assign last_s   = (cnt_r == CW'(WIDTH - 1));
    // On the last shift br_r is exactly the borrow into the MSB.
    assign br_msb_s = br_r;

    // Next-state logic for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_s = ST_SHIFT;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_s) begin
                    next_s = ST_DONE;
                end else begin
                    next_s = ST_SHIFT;
                end
            end
            ST_DONE: next_s = ST_IDLE;
            default: next_s = ST_IDLE;
        endcase
    end

    // State, datapath shift registers and result/flag output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            a_sh_r     <= '0;
            b_sh_r     <= '0;
            res_r      <= '0;
            cnt_r      <= '0;
            br_r       <= 1'b0;
            diff_r     <= '0;
            borrow_r   <= 1'b0;
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r <= next_s;
            busy_r  <= (next_s != ST_IDLE);
            done_r  <= (next_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_sh_r <= a;
                        b_sh_r <= b;
                        br_r   <= b_in;
                        cnt_r  <= '0;
                        res_r  <= '0;
                    end
                end
                ST_SHIFT: begin
                    a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
                    res_r  <= {d_s, res_r[WIDTH-1:1]};
                    br_r   <= bo_s;
                    cnt_r  <= cnt_r + CW'(1);
                    if (last_s) begin
                        diff_r     <= {d_s, res_r[WIDTH-1:1]};
                        borrow_r   <= bo_s;
                        overflow_r <= br_msb_s ^ bo_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign diff     = diff_r;
    assign borrow   = borrow_r;
    assign overflow = overflow_r;

endmodule
